// File: rtl/direction_controller_if.sv
// direction_controller_if: measurement/commit inputs and heading
// outputs of the steering direction controller.
interface direction_controller_if;
  logic       sample;
  logic       esq;
  logic       dir;
  logic       commit;
  logic [1:0] direction;
  logic       turn_pending;
  logic [2:0] db_state;

  modport master (
    output sample, esq, dir, commit,
    input  direction, turn_pending, db_state
  );

  modport slave (
    input  sample, esq, dir, commit,
    output direction, turn_pending, db_state
  );
endinterface

// File: rtl/direction_controller.sv
// direction_controller: debounced left/right steering, one turn per commit.
// Optional DIRECTION_REPEAT_EN: a held hand re-arms without release.
module direction_controller #(
  parameter int         FILTER_LEN = 4,
  parameter logic [1:0] INIT_DIR   = 2'b00
) (
  input logic                  clock,
  input logic                  reset,
  input logic                  clear,
  direction_controller_if.slave bus
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LEN  = CW'(FILTER_LEN);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = '0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CNT_L    = 3'd1,
    CNT_R    = 3'd2,
    ARM_L    = 3'd3,
    ARM_R    = 3'd4,
    WAIT_REL = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dir_q, dir_d;

  logic          is_l, is_r, is_n;
  logic [CW-1:0] cnt_inc;
  logic          arm_now;
  state_t        first_l, first_r;

  // Classify the sample and compute the saturating counter step.
  always_comb begin
    is_l    = bus.sample & bus.esq & ~bus.dir;
    is_r    = bus.sample & ~bus.esq & bus.dir;
    is_n    = bus.sample & ~(is_l | is_r);
    cnt_inc = (cnt_q == LEN) ? cnt_q : cnt_q + ONE;
    arm_now = (cnt_inc == LEN);
    first_l = (LEN == ONE) ? ARM_L : CNT_L;
    first_r = (LEN == ONE) ? ARM_R : CNT_R;
  end

  // Next-state, counter and heading update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (is_l) begin
          state_d = first_l;
          cnt_d   = ONE;
        end else if (is_r) begin
          state_d = first_r;
          cnt_d   = ONE;
        end
      end
      CNT_L: begin
        if (is_l) begin
          cnt_d   = cnt_inc;
          state_d = arm_now ? ARM_L : CNT_L;
        end else if (is_r) begin
          state_d = first_r;
          cnt_d   = ONE;
        end else if (is_n) begin
          state_d = IDLE;
          cnt_d   = ZERO;
        end
      end
      CNT_R: begin
        if (is_r) begin
          cnt_d   = cnt_inc;
          state_d = arm_now ? ARM_R : CNT_R;
        end else if (is_l) begin
          state_d = first_l;
          cnt_d   = ONE;
        end else if (is_n) begin
          state_d = IDLE;
          cnt_d   = ZERO;
        end
      end
      ARM_L: begin
        if (bus.commit) begin
          dir_d = dir_q - 2'd1;
          cnt_d = ZERO;
`ifdef DIRECTION_REPEAT_EN
          state_d = CNT_L;
`else
          state_d = WAIT_REL;
`endif
        end
      end
      ARM_R: begin
        if (bus.commit) begin
          dir_d = dir_q + 2'd1;
          cnt_d = ZERO;
`ifdef DIRECTION_REPEAT_EN
          state_d = CNT_R;
`else
          state_d = WAIT_REL;
`endif
        end
      end
      WAIT_REL: begin
        if (is_n) begin
          state_d = IDLE;
          cnt_d   = ZERO;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = ZERO;
      end
    endcase
  end

  // State registers; reset outranks clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= ZERO;
      dir_q   <= INIT_DIR;
    end else if (clear) begin
      state_q <= IDLE;
      cnt_q   <= ZERO;
      dir_q   <= INIT_DIR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Registered outputs straight from state.
  always_comb begin
    bus.direction    = dir_q;
    bus.turn_pending = (state_q == ARM_L) ||
                       (state_q == ARM_R);
    bus.db_state     = state_q;
  end

endmodule
